// File: rtl/chol_diag_prep.sv
// rtl/chol_diag_prep.sv - Cholesky diagonal residual accumulator and latency-timed sqrt feeder.
// Optional diag_err output (non-positive-definite flag) is enabled by defining CHOL_DIAG_ERR_EN.
module chol_diag_prep #(
    parameter int SQRT_LAT = 17,
    parameter int N_W      = 4,
    parameter int ACC_W    = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clken,
    input  logic                    start,
    input  logic [31:0]             a_diag,
    input  logic [N_W-1:0]          n_terms,
    input  logic                    l_valid,
    input  logic signed [15:0]      l_data,
    output logic                    busy,
    output logic                    sqrt_valid,
    output logic [31:0]             sqrt_data,
    input  logic [31:0]             sqrt_out,
    output logic                    diag_valid,
`ifdef CHOL_DIAG_ERR_EN
    output logic                    diag_err,
`endif
    output logic [31:0]             diag_out
);

    localparam int WC_W = $clog2(SQRT_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ISSUE, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]          cnt_q, cnt_d;
    logic [WC_W-1:0]         wcnt_q, wcnt_d;
    logic [31:0]             sqrt_data_q, sqrt_data_d;
    logic [31:0]             diag_out_q, diag_out_d;
    logic                    diag_valid_q, diag_valid_d;
    logic signed [31:0]      l_ext, l_sq;
    logic                    acc_pos;
`ifdef CHOL_DIAG_ERR_EN
    logic                    clamp_q, clamp_d;
    logic                    diag_err_q, diag_err_d;
`endif

    // The square of a 16-bit signed value is at most 2^30, so it stays positive in 32 bits.
    assign l_ext   = 32'(l_data);
    assign l_sq    = l_ext * l_ext;
    assign acc_pos = !acc_d[ACC_W-1] && (acc_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            sqrt_data_q  <= '0;
            diag_out_q   <= '0;
            diag_valid_q <= 1'b0;
`ifdef CHOL_DIAG_ERR_EN
            clamp_q      <= 1'b0;
            diag_err_q   <= 1'b0;
`endif
        end else if (clken) begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            sqrt_data_q  <= sqrt_data_d;
            diag_out_q   <= diag_out_d;
            diag_valid_q <= diag_valid_d;
`ifdef CHOL_DIAG_ERR_EN
            clamp_q      <= clamp_d;
            diag_err_q   <= diag_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        sqrt_data_d  = sqrt_data_q;
        diag_out_d   = diag_out_q;
        diag_valid_d = 1'b0;
`ifdef CHOL_DIAG_ERR_EN
        clamp_d      = clamp_q;
        diag_err_d   = diag_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = {{(ACC_W-32){1'b0}}, a_diag};
                    cnt_d   = n_terms;
                    state_d = (n_terms == '0) ? S_ISSUE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (l_valid) begin
                    acc_d = acc_q - ACC_W'(l_sq);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == N_W'(1)) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wcnt_d  = WC_W'(SQRT_LAT);
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 1'b1;
                // The decrement to zero marks the cycle the sqrt result is stable.
                if (wcnt_q == WC_W'(1)) begin
                    diag_out_d   = sqrt_out;
                    diag_valid_d = 1'b1;
                    state_d      = S_IDLE;
`ifdef CHOL_DIAG_ERR_EN
                    diag_err_d   = clamp_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Register the clamped residual on the way into ISSUE so it is stable for the issue cycle and after.
        if (state_d == S_ISSUE) begin
            sqrt_data_d = acc_pos ? acc_d[31:0] : 32'd0;
`ifdef CHOL_DIAG_ERR_EN
            clamp_d     = !acc_pos;
`endif
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        sqrt_valid = (state_q == S_ISSUE);
        sqrt_data  = sqrt_data_q;
        diag_valid = diag_valid_q;
        diag_out   = diag_out_q;
`ifdef CHOL_DIAG_ERR_EN
        diag_err   = diag_err_q;
`endif
    end

endmodule

// File: tb/tb_chol_diag_prep.sv
// tb/tb_chol_diag_prep.sv - scoreboard bench for chol_diag_prep with an integer-sqrt latency model.
module tb_chol_diag_prep;

    localparam int SQRT_LAT = 17;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clken = 1'b1;
    logic               start = 1'b0;
    logic [31:0]        a_diag = '0;
    logic [3:0]         n_terms = '0;
    logic               l_valid = 1'b0;
    logic signed [15:0] l_data = '0;
    logic               busy, sqrt_valid, diag_valid;
    logic [31:0]        sqrt_data, diag_out, sqrt_out;
    logic               err_bit;
    logic [67:0]        outs;

    chol_diag_prep #(.SQRT_LAT(SQRT_LAT), .N_W(4), .ACC_W(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .start      (start),
        .a_diag     (a_diag),
        .n_terms    (n_terms),
        .l_valid    (l_valid),
        .l_data     (l_data),
        .busy       (busy),
        .sqrt_valid (sqrt_valid),
        .sqrt_data  (sqrt_data),
        .sqrt_out   (sqrt_out),
        .diag_valid (diag_valid),
`ifdef CHOL_DIAG_ERR_EN
        .diag_err   (err_bit),
`endif
        .diag_out   (diag_out)
    );

`ifndef CHOL_DIAG_ERR_EN
    assign err_bit = 1'b0;
`endif
    assign outs = {err_bit, busy, sqrt_valid, sqrt_data, diag_valid, diag_out};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] v;
        bit          err;
        int          c;
    } exp_t;
    exp_t sq_q[$];
    exp_t dg_q[$];

    function automatic logic [31:0] isqrt(input longint x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sqrt core model: result of an issued value appears SQRT_LAT enabled cycles later; junk otherwise.
    logic [31:0] pipe [SQRT_LAT];
    always @(posedge clk) begin
        if (clken) begin
            pipe[0] <= (sqrt_valid === 1'b1) ? isqrt(longint'(sqrt_data)) : 32'h00BADBAD;
            for (int i = 1; i < SQRT_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign sqrt_out = pipe[SQRT_LAT-1];

    exp_t me;
    always @(negedge clk) begin
        if (!rst && clken) begin
            if (sqrt_valid === 1'b1) begin
                if (sq_q.size() == 0) chk("sqrt_valid_unexpected", 1, 0);
                else begin
                    me = sq_q.pop_front();
                    chk("sqrt_data", sqrt_data, me.v);
                    chk("sqrt_valid_cycle", cyc, me.c);
                end
            end
            if (diag_valid === 1'b1) begin
                if (dg_q.size() == 0) chk("diag_valid_unexpected", 1, 0);
                else begin
                    me = dg_q.pop_front();
                    chk("diag_out", diag_out, me.v);
                    chk("diag_valid_cycle", cyc, me.c);
`ifdef CHOL_DIAG_ERR_EN
                    chk("diag_err", err_bit, me.err);
`endif
                end
            end
        end
    end

    logic signed [15:0] tl [16];

    task automatic idle(input int k);
        repeat (k) begin
            start = 1'b0; clken = 1'b1;
            l_valid = 1'($urandom_range(0, 1));
            l_data = 16'($urandom);
            @(posedge clk); #1;
        end
        l_valid = 1'b0;
    endtask

    task automatic do_diag(input logic [31:0] a, input int n, input int low_off, input int low_len,
                           input bit glitch, input int rst_off);
        longint r;
        exp_t e, d;
        int s, t, endc, c;
        logic [67:0] snap;
        r = longint'(a);
        for (int i = 0; i < n; i++) r -= longint'(tl[i]) * longint'(tl[i]);
        e.v = (r > 0) ? r[31:0] : 32'd0;
        e.err = (r <= 0);
        s = cyc;
        t = s + n + 1;
        e.c = t;
        sq_q.push_back(e);
        d.v = isqrt(longint'(e.v));
        d.err = e.err;
        d.c = t + SQRT_LAT + 1 + low_len;
        if (rst_off < 0) dg_q.push_back(d);
        start = 1'b1; a_diag = a; n_terms = 4'(n); clken = 1'b1; l_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            l_valid = 1'b1;
            l_data = tl[i];
            if (glitch && i == 0) begin
                start = 1'b1; a_diag = $urandom; n_terms = '0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        l_valid = 1'b0;
        endc = (rst_off >= 0) ? t + 25 : d.c;
        snap = '0;
        while (cyc < endc) begin
            c = cyc;
            start = 1'b0; clken = 1'b1; rst = 1'b0;
            if (low_len > 0) begin
                if (c == t + low_off) snap = outs;
                if (c > t + low_off && c <= t + low_off + low_len) chk("hold_during_clken_low", outs, snap);
                if (c >= t + low_off && c < t + low_off + low_len) clken = 1'b0;
            end
            if (glitch && c == t + 3) begin
                start = 1'b1; a_diag = $urandom; n_terms = 4'($urandom);
            end
            if (rst_off >= 0) begin
                if (c == t + rst_off + 1) chk("outputs_after_reset", outs, 0);
                if (c == t + rst_off) rst = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; clken = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, lo_off, lo_len;
        logic [31:0] a;
        bit gl;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs, 0);
        rst = 1'b0;
        idle(2);

        do_diag(32'd100, 0, 0, 0, 1'b0, -1);
        idle(1);
        chk("busy_low_after_diag", busy, 0);

        tl[0] = 16'sd10; tl[1] = -16'sd20;
        do_diag(32'd1000, 2, 0, 0, 1'b0, -1);
        tl[0] = 16'sd6; tl[1] = -16'sd8;
        do_diag(32'd100, 2, 0, 0, 1'b0, -1);
        tl[0] = 16'sd6; tl[1] = -16'sd9;
        do_diag(32'd100, 2, 0, 0, 1'b0, -1);
        idle(1);
        tl[0] = 16'sd3; tl[1] = 16'sd4; tl[2] = -16'sd5;
        do_diag(32'd5000, 3, 0, 0, 1'b1, -1);
        do_diag(32'd400, 0, 5, 5, 1'b0, -1);
        do_diag(32'd900, 0, 0, 0, 1'b0, 8);
        do_diag(32'd49, 0, 0, 0, 1'b0, -1);
        idle(2);

        repeat (30) begin
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++)
                tl[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($signed($urandom_range(0, 400)) - 200);
            a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 2000)) : $urandom;
            lo_off = 0; lo_len = 0;
            if ($urandom_range(0, 3) == 0) begin
                lo_off = $urandom_range(1, 16);
                lo_len = $urandom_range(1, 4);
            end
            gl = 1'($urandom_range(0, 1));
            do_diag(a, n, lo_off, lo_len, gl, -1);
            idle($urandom_range(0, 2));
        end

        idle(25);
        chk("sqrt_queue_drained", 68'(sq_q.size()), 0);
        chk("diag_queue_drained", 68'(dg_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chol_diag_prep.md
Name: chol_diag_prep

Overview:
- Upstream feeder for the Cholesky diagonal square-root stage.
- For diagonal j it takes a_jj and streams the already-computed row terms L_jk (k<j). It forms the residual r = a_jj − Σ L_jk².
- It clamps r to non-negative, issues r to the sqrt stage with a one-cycle valid, counts the sqrt's fixed latency, then captures and presents L_jj.
- It is the only driver of the sqrt stage's data/valid inputs. The sqrt stage's own valid output is unused because sampling is latency-timed here.

Parameters:
- SQRT_LAT, 17: clken-qualified cycles from the sqrt input sample to its result being stable; must match the sqrt core configuration, ≥1.
- N_W, 4: width of the term count; max terms per diagonal = 2^N_W − 1.
- ACC_W, 40: signed accumulator width; must be ≥ 35 + N_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clken  in  1  clock enable; when low, every register holds, including the latency counter
- start  in  1  begin a diagonal; accepted only in IDLE
- a_diag  in  32  unsigned a_jj, sampled with start
- n_terms  in  N_W  number of L_jk terms to follow, sampled with start
- l_valid  in  1  term strobe
- l_data  in  16  signed L_jk
- busy  out  1  high in every state except IDLE
- sqrt_valid  out  1  one-cycle issue strobe to the sqrt stage
- sqrt_data  out  32  clamped residual to the sqrt stage
- sqrt_out  in  32  sqrt result; upper 8 bits are zero
- diag_valid  out  1  one-cycle result strobe
- diag_out  out  32  captured L_jj, held until the next capture

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clken):
  - state=IDLE, acc=0, counters=0.
  - busy, sqrt_valid, diag_valid = 0; sqrt_data = 0; diag_out = 0.
  - A reset mid-operation abandons the diagonal. The sqrt core's in-flight result is never captured.
- All transitions below require clken=1.
- IDLE:
  - start → acc = zero-extended a_diag, cnt = n_terms.
  - Next state is ISSUE if n_terms=0, else ACCUM.
  - l_valid in IDLE is ignored.
- ACCUM:
  - Each l_valid: acc −= l_data², where the square is a 32-bit unsigned product (max 2^30), and cnt decrements.
  - When the decrement takes cnt to 0 → ISSUE.
  - start is ignored while busy.
- ISSUE (one cycle, call it T):
  - sqrt_valid=1.
  - sqrt_data = acc[31:0] if acc > 0, else 0 (clamp).
  - Next state WAIT with wcnt = SQRT_LAT.
  - sqrt_data holds its value after T; sqrt_valid is high only in T.
- WAIT:
  - wcnt decrements per clken cycle.
  - On the cycle wcnt reaches 0, which is cycle T+SQRT_LAT, sqrt_out is registered into diag_out.
  - diag_valid=1 for exactly cycle T+SQRT_LAT+1, then state returns to IDLE.
- Latency: for n_terms=0, start at cycle S gives sqrt_valid at S+1 and diag_valid at S+SQRT_LAT+2. Each term adds one cycle per l_valid.
- Back-to-back: a start presented in the cycle that diag_valid is high is accepted, because the state is IDLE that cycle.
- Arithmetic: acc is signed ACC_W and never overflows within the parameter constraint. acc ≤ 0 ⇒ sqrt input 0 ⇒ L_jj = 0.

Optional Feature:
- Macro: CHOL_DIAG_ERR_EN.
- When defined:
  - Adds output diag_err (1 bit, reset 0), set alongside diag_valid when the issued residual was clamped (acc ≤ 0, i.e. matrix not positive definite).
  - diag_err holds until the next diag_valid, which rewrites it.
- When undefined: the port does not exist; clamping still occurs silently and all other behaviour is identical.

Test Plan:
- Bench sqrt model: integer isqrt with SQRT_LAT=17.
- a_diag=100, n_terms=0, start at cycle S → sqrt_valid/sqrt_data=100 at S+1; diag_valid with diag_out=10 at S+19; busy low at S+20.
- a_diag=1000, n_terms=2, l_data=10 then −20 on consecutive cycles → sqrt_data=500; diag_out=22 (integer sqrt of 500).
- a_diag=100, terms 6, −8 → residual 0, sqrt_data=0, diag_out=0; diag_err=1 with CHOL_DIAG_ERR_EN. Repeat with terms 6, −9 (residual −17) → same result.
- start pulsed during ACCUM and during WAIT → ignored: a single diag_valid, and the result is unchanged.
- clken held low for 5 cycles inside WAIT → diag_valid delayed by exactly 5 cycles, and all outputs held throughout.
- rst asserted at T+8 of WAIT → next cycle every output is 0 and state is IDLE; no diag_valid appears; a fresh start with a_diag=49 yields diag_out=7.
